blake2b_msg_packer: RTL and testbench

Message-side feeder for the BLAKE2b compression core. It accepts a 64-bit byte stream with byte-enables and packs it into 128-byte message blocks. Each block is tagged with the cumulative byte counter t and the final-block flag f, as the compression core requires. It sits between the host/AXI stream ingress and the blake2b core's block input. It resolves the exact-multiple-of-128 final-block ambiguity before handing a block over.

---
 rtl/blake2_pkg.sv | 26 ++
 rtl/blake2b_msg_packer.sv | 125 ++++++++++++
 tb/tb_blake2b_msg_packer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/blake2_pkg.sv
// Shared constants, block type and byte-enable helpers for the BLAKE2b message path.
package blake2_pkg;

  localparam int BLOCK_BYTES     = 128;
  localparam int WORD_BYTES      = 8;
  localparam int WORDS_PER_BLOCK = 16;

  typedef logic [WORDS_PER_BLOCK-1:0][63:0] blk_t;

  // Contiguous-from-bit-0 masks are exactly those of the form 2^n-1, including 0 and all-ones.
  function automatic logic keep_ok(input logic [WORD_BYTES-1:0] keep);
    logic [WORD_BYTES-1:0] keep_inc;
    keep_inc = keep + 8'd1;
    return ((keep & keep_inc) == '0);
  endfunction

  function automatic logic [3:0] keep_cnt(input logic [WORD_BYTES-1:0] keep);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      n = n + {3'd0, keep[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/blake2b_msg_packer.sv
// Packs a 64-bit byte stream into 128-byte BLAKE2b message blocks tagged with t and final.
module blake2b_msg_packer
  import blake2_pkg::*;
#(
  parameter int CTR_BITS = 128
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [63:0]         i_dat,
  input  logic [7:0]          i_keep,
  input  logic                i_val,
  input  logic                i_last,
  output logic                o_rdy,
  output logic [1023:0]       o_blk,
  output logic [CTR_BITS-1:0] o_t,
  output logic                o_final,
  output logic                o_val,
  input  logic                i_rdy,
  output logic                o_err
);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [CTR_BITS-1:0] cnt_q, cnt_d;
  blk_t                buf_q, buf_d;
  logic                final_q, final_d;
  logic                err_q, err_d;

  logic [63:0]         masked;
  logic                word_err;
  logic                hold_take;
  logic [CTR_BITS-1:0] add_bytes;

  always_comb begin
    masked = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      masked[8*k +: 8] = i_keep[k] ? i_dat[8*k +: 8] : 8'h00;
    end
  end

  assign word_err  = !keep_ok(i_keep) || (!i_last && (i_keep != 8'hFF));
  assign add_bytes = {{(CTR_BITS-4){1'b0}}, keep_cnt(i_keep)};

  // A full block only learns it is final if the very next word is an empty last word.
  assign hold_take = (state_q == ST_HOLD) && i_val && i_last && (i_keep == 8'h00);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    final_d = final_q;
    err_d   = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (i_val) begin
          if (word_err) begin
            err_d = 1'b1;
          end else begin
            buf_d[idx_q] = masked;
            cnt_d        = cnt_q + add_bytes;
            if (i_last) begin
              state_d = ST_EMIT;
              final_d = 1'b1;
            end else if (idx_q == 4'd15) begin
              state_d = ST_HOLD;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (i_val) begin
          state_d = ST_EMIT;
          final_d = hold_take;
        end
      end
      ST_EMIT: begin
        if (i_rdy) begin
          buf_d   = '0;
          idx_d   = 4'd0;
          final_d = 1'b0;
          state_d = ST_FILL;
          if (final_q) begin
            cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_FILL;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      buf_q   <= '0;
      final_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      final_q <= final_d;
      err_q   <= err_d;
    end
  end

  assign o_rdy   = (state_q == ST_FILL) || hold_take;
  assign o_val   = (state_q == ST_EMIT);
  assign o_blk   = buf_q;
  assign o_t     = cnt_q;
  assign o_final = final_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_blake2b_msg_packer.sv
// Directed bench for blake2b_msg_packer: hand-computed blocks, counters and flags.
module tb_blake2b_msg_packer;
  import blake2_pkg::*;

  localparam int CTR_BITS = 128;

  logic                clk = 1'b0;
  logic                rst;
  logic [63:0]         i_dat;
  logic [7:0]          i_keep;
  logic                i_val;
  logic                i_last;
  logic                o_rdy;
  logic [1023:0]       o_blk;
  logic [CTR_BITS-1:0] o_t;
  logic                o_final;
  logic                o_val;
  logic                i_rdy;
  logic                o_err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [1023:0]       exp_blk;
  logic [1023:0]       snap_blk;
  logic [CTR_BITS-1:0] snap_t;
  logic                snap_f;

  blake2b_msg_packer #(.CTR_BITS(CTR_BITS)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_dat  (i_dat),
    .i_keep (i_keep),
    .i_val  (i_val),
    .i_last (i_last),
    .o_rdy  (o_rdy),
    .o_blk  (o_blk),
    .o_t    (o_t),
    .o_final(o_final),
    .o_val  (o_val),
    .i_rdy  (i_rdy),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
    total++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    i_dat  = d;
    i_keep = k;
    i_last = l;
    i_val  = 1'b1;
    n = 0;
    while (!o_rdy && n < 50) begin
      step();
      n++;
    end
    if (n == 50) begin
      total++;
      fail_cnt++;
      $error("FAIL push_timeout: o_rdy observed 0 expected 1");
    end
    step();
    i_val  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic take();
    i_rdy = 1'b1;
    step();
    i_rdy = 1'b0;
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'h0101010101010101 * 64'(i + 1);
  endfunction

  initial begin
    rst = 1'b1; i_dat = '0; i_keep = '0; i_val = 1'b0; i_last = 1'b0; i_rdy = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    chk("rst_val",   1024'(o_val),   1024'(0));
    chk("rst_err",   1024'(o_err),   1024'(0));
    chk("rst_blk",   o_blk,          1024'(0));
    chk("rst_t",     1024'(o_t),     1024'(0));
    chk("rst_final", 1024'(o_final), 1024'(0));
    chk("rst_rdy",   1024'(o_rdy),   1024'(1));

    // "abc": o_val must be up the cycle right after the accept
    i_dat = 64'h0000000000636261; i_keep = 8'h07; i_last = 1'b1; i_val = 1'b1;
    step();
    i_val = 1'b0; i_last = 1'b0;
    chk("abc_val",   1024'(o_val),   1024'(1));
    chk("abc_blk",   o_blk,          1024'h636261);
    chk("abc_t",     1024'(o_t),     1024'(3));
    chk("abc_final", 1024'(o_final), 1024'(1));
    chk("abc_rdy",   1024'(o_rdy),   1024'(0));
    take();
    chk("abc_done_val", 1024'(o_val), 1024'(0));

    // Empty message: unkept bytes must be zeroed
    push(64'hDEADBEEFCAFEF00D, 8'h00, 1'b1);
    chk("empty_val",   1024'(o_val),   1024'(1));
    chk("empty_blk",   o_blk,          1024'(0));
    chk("empty_t",     1024'(o_t),     1024'(0));
    chk("empty_final", 1024'(o_final), 1024'(1));
    take();

    // 128 bytes, last on word 16
    exp_blk = '0;
    for (int i = 0; i < 16; i++) exp_blk[64*i +: 64] = pat(i);
    for (int i = 0; i < 16; i++) push(pat(i), 8'hFF, (i == 15));
    chk("b128_val",   1024'(o_val),   1024'(1));
    chk("b128_blk",   o_blk,          exp_blk);
    chk("b128_t",     1024'(o_t),     1024'(128));
    chk("b128_final", 1024'(o_final), 1024'(1));
    take();

    // 128 bytes then an empty last word consumed from HOLD
    for (int i = 0; i < 16; i++) push(pat(i), 8'hFF, 1'b0);
    step();
    chk("hold_val", 1024'(o_val), 1024'(0));
    chk("hold_rdy", 1024'(o_rdy), 1024'(0));
    i_dat = 64'h0; i_keep = 8'h00; i_last = 1'b1; i_val = 1'b1;
    #1;
    chk("hold_peek_rdy", 1024'(o_rdy), 1024'(1));
    step();
    i_val = 1'b0; i_last = 1'b0;
    chk("hold_emit_val", 1024'(o_val),   1024'(1));
    chk("hold_blk",      o_blk,          exp_blk);
    chk("hold_t",        1024'(o_t),     1024'(128));
    chk("hold_final",    1024'(o_final), 1024'(1));
    take();
    chk("hold_after_rdy", 1024'(o_rdy), 1024'(1));

    // 136 bytes: block 1 emitted while word 17 waits
    for (int i = 0; i < 16; i++) push(pat(i), 8'hFF, 1'b0);
    i_dat = 64'hA5A5A5A5A5A5A5A5; i_keep = 8'hFF; i_last = 1'b1; i_val = 1'b1;
    step();
    chk("b136a_val",   1024'(o_val),   1024'(1));
    chk("b136a_t",     1024'(o_t),     1024'(128));
    chk("b136a_final", 1024'(o_final), 1024'(0));
    chk("b136a_rdy",   1024'(o_rdy),   1024'(0));
    chk("b136a_blk",   o_blk,          exp_blk);
    i_rdy = 1'b1;
    step();
    i_rdy = 1'b0;
    chk("b136_fill_rdy", 1024'(o_rdy), 1024'(1));
    step();
    i_val = 1'b0; i_last = 1'b0;
    chk("b136b_val",   1024'(o_val),   1024'(1));
    chk("b136b_t",     1024'(o_t),     1024'(136));
    chk("b136b_final", 1024'(o_final), 1024'(1));
    chk("b136b_blk",   o_blk,          1024'h0A5A5A5A5A5A5A5A5);

    // Backpressure: outputs frozen for 5 cycles
    snap_blk = o_blk; snap_t = o_t; snap_f = o_final;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_blk",   o_blk,          snap_blk);
      chk("bp_t",     1024'(o_t),     1024'(snap_t));
      chk("bp_final", 1024'(o_final), 1024'(snap_f));
      chk("bp_rdy",   1024'(o_rdy),   1024'(0));
      chk("bp_val",   1024'(o_val),   1024'(1));
    end
    take();

    // Counter restarts after a final block
    push(64'h00000000000000EE, 8'h01, 1'b1);
    chk("restart_t",   1024'(o_t), 1024'(1));
    chk("restart_blk", o_blk,      1024'hEE);
    take();

    // Protocol errors: discarded, no counter or slot change
    push(64'h1111111111111111, 8'hFF, 1'b0);
    chk("ok_err", 1024'(o_err), 1024'(0));
    push(64'h2222222222222222, 8'h05, 1'b0);
    chk("err05", 1024'(o_err), 1024'(1));
    step();
    chk("err05_pulse", 1024'(o_err), 1024'(0));
    push(64'h3333333333333333, 8'h0F, 1'b0);
    chk("err0F", 1024'(o_err), 1024'(1));
    push(64'h0000000000002211, 8'h03, 1'b1);
    chk("err_after_err", 1024'(o_err), 1024'(0));
    chk("err_t",         1024'(o_t),   1024'(10));
    exp_blk = '0;
    exp_blk[63:0]   = 64'h1111111111111111;
    exp_blk[127:64] = 64'h0000000000002211;
    chk("err_blk", o_blk, exp_blk);
    take();

    // Reset mid-message drops everything
    for (int i = 0; i < 5; i++) push(pat(i), 8'hFF, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_val", 1024'(o_val), 1024'(0));
    chk("mrst_blk", o_blk,        1024'(0));
    push(64'h0000000000636261, 8'h07, 1'b1);
    chk("mrst_abc_t",   1024'(o_t), 1024'(3));
    chk("mrst_abc_blk", o_blk,      1024'h636261);
    take();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
